mem_arbiter: RTL and testbench

- Two-client arbiter directly upstream of the DDR3 memory stage, in the ui_clk domain.
- Port A serves the GBA cartridge-bus engine; port B serves the host link.
- Selects one request at a time round-robin, drives the mux_mem_interface command side, and returns read data to the issuing client.
- Keeps at most one read outstanding and recovers from lost read responses with a timeout.

---
 rtl/mem_arbiter_if.sv | 23 ++
 rtl/mem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Command/response bundle between the two-client arbiter and the DDR3 memory stage.
// The arbiter uses the mux side; the memory stage (or a bench model) uses the mem side.
interface mux_mem_interface;
   logic        mem_rd;
   logic        mem_wr;
   logic [25:0] mem_addr;
   logic [31:0] mem_wr_data;
   logic [1:0]  mem_data_width;
   logic        mem_rd_ready;
   logic        mem_wr_ready;
   logic [31:0] mem_rd_data;
   logic        mem_rd_valid;

   modport mux (
      output mem_rd, mem_wr, mem_addr, mem_wr_data, mem_data_width,
      input  mem_rd_ready, mem_wr_ready, mem_rd_data, mem_rd_valid
   );

   modport mem (
      input  mem_rd, mem_wr, mem_addr, mem_wr_data, mem_data_width,
      output mem_rd_ready, mem_wr_ready, mem_rd_data, mem_rd_valid
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for the cartridge engine (A) and host link (B) in front of DDR3.
// One command at a time, a single read outstanding, timeout recovery with stale-response drop.
module mem_arbiter #(
   parameter int          ADDR_W     = 26,
   parameter int          RD_TIMEOUT = 1024,
   parameter logic [31:0] ERR_DATA   = 32'hFFFF_FFFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [31:0]       a_wdata,
   input  logic [1:0]        a_width,
   output logic              a_gnt,
   output logic              a_rvalid,
   output logic [31:0]       a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [31:0]       b_wdata,
   input  logic [1:0]        b_width,
   output logic              b_gnt,
   output logic              b_rvalid,
   output logic [31:0]       b_rdata,
   output logic              rd_err,
   mux_mem_interface.mux     mux_mem
);

   localparam int TW = (RD_TIMEOUT > 2) ? $clog2(RD_TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(RD_TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE_WR, ISSUE_RD, WAIT_RD} state_t;

   state_t            state, state_n;
   logic              last_b, last_b_n;
   logic              owner_b, owner_b_n;
   logic              rd_cmd, rd_cmd_n;
   logic              wr_cmd, wr_cmd_n;
   logic [ADDR_W-1:0] cmd_addr, cmd_addr_n;
   logic [31:0]       cmd_wdata, cmd_wdata_n;
   logic [1:0]        cmd_width, cmd_width_n;
   logic              a_gnt_n, b_gnt_n, a_rvalid_n, b_rvalid_n, rd_err_n;
   logic [31:0]       a_rdata_n, b_rdata_n;
   logic [2:0]        stale_cnt, stale_cnt_n;
   logic [TW-1:0]     tmo_cnt, tmo_cnt_n;

   // On a tie the port that did not win last time takes the bus.
   logic              pick_b;
   logic              sel_we;
   logic [1:0]        sel_width;
   assign pick_b    = b_req && (!a_req || !last_b);
   assign sel_we    = pick_b ? b_we : a_we;
   assign sel_width = pick_b ? b_width : a_width;

   assign mux_mem.mem_rd         = rd_cmd;
   assign mux_mem.mem_wr         = wr_cmd;
   assign mux_mem.mem_addr       = cmd_addr;
   assign mux_mem.mem_wr_data    = cmd_wdata;
   assign mux_mem.mem_data_width = cmd_width;

   always_comb begin
      state_n     = state;
      last_b_n    = last_b;
      owner_b_n   = owner_b;
      rd_cmd_n    = rd_cmd;
      wr_cmd_n    = wr_cmd;
      cmd_addr_n  = cmd_addr;
      cmd_wdata_n = cmd_wdata;
      cmd_width_n = cmd_width;
      a_gnt_n     = 1'b0;
      b_gnt_n     = 1'b0;
      a_rvalid_n  = 1'b0;
      b_rvalid_n  = 1'b0;
      a_rdata_n   = a_rdata;
      b_rdata_n   = b_rdata;
      rd_err_n    = rd_err;
      tmo_cnt_n   = tmo_cnt;
      stale_cnt_n = stale_cnt;

      // A response owed to a timed-out read is swallowed wherever it shows up.
      if (mux_mem.mem_rd_valid && stale_cnt != 3'd0)
         stale_cnt_n = stale_cnt - 3'd1;

      case (state)
         IDLE: begin
            if (a_req || b_req) begin
               owner_b_n   = pick_b;
               last_b_n    = pick_b;
               a_gnt_n     = !pick_b;
               b_gnt_n     = pick_b;
               cmd_addr_n  = pick_b ? b_addr : a_addr;
               cmd_wdata_n = pick_b ? b_wdata : a_wdata;
               cmd_width_n = sel_width;
               if (!sel_we)
                  state_n = ISSUE_RD;
               else if (sel_width != 2'b00)
                  state_n = ISSUE_WR;
            end
         end
         ISSUE_WR: begin
            if (!wr_cmd)
               wr_cmd_n = 1'b1;
            else if (mux_mem.mem_wr_ready) begin
               wr_cmd_n = 1'b0;
               state_n  = IDLE;
            end
         end
         ISSUE_RD: begin
            if (!rd_cmd)
               rd_cmd_n = 1'b1;
            else if (mux_mem.mem_rd_ready) begin
               rd_cmd_n  = 1'b0;
               tmo_cnt_n = '0;
               state_n   = WAIT_RD;
            end
         end
         WAIT_RD: begin
            tmo_cnt_n = tmo_cnt + TW'(1);
            if (mux_mem.mem_rd_valid && stale_cnt == 3'd0) begin
               a_rvalid_n = !owner_b;
               b_rvalid_n = owner_b;
               if (owner_b) b_rdata_n = mux_mem.mem_rd_data;
               else         a_rdata_n = mux_mem.mem_rd_data;
               state_n = IDLE;
            end else if (tmo_cnt == TMO_LAST) begin
               a_rvalid_n = !owner_b;
               b_rvalid_n = owner_b;
               if (owner_b) b_rdata_n = ERR_DATA;
               else         a_rdata_n = ERR_DATA;
               rd_err_n = 1'b1;
               if (stale_cnt_n != 3'd7)
                  stale_cnt_n = stale_cnt_n + 3'd1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Every output and piece of arbiter state is a flop loaded from the next-state logic.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         last_b    <= 1'b1;
         owner_b   <= 1'b0;
         rd_cmd    <= 1'b0;
         wr_cmd    <= 1'b0;
         cmd_addr  <= '0;
         cmd_wdata <= '0;
         cmd_width <= '0;
         a_gnt     <= 1'b0;
         b_gnt     <= 1'b0;
         a_rvalid  <= 1'b0;
         b_rvalid  <= 1'b0;
         a_rdata   <= '0;
         b_rdata   <= '0;
         rd_err    <= 1'b0;
         stale_cnt <= '0;
         tmo_cnt   <= '0;
      end else begin
         state     <= state_n;
         last_b    <= last_b_n;
         owner_b   <= owner_b_n;
         rd_cmd    <= rd_cmd_n;
         wr_cmd    <= wr_cmd_n;
         cmd_addr  <= cmd_addr_n;
         cmd_wdata <= cmd_wdata_n;
         cmd_width <= cmd_width_n;
         a_gnt     <= a_gnt_n;
         b_gnt     <= b_gnt_n;
         a_rvalid  <= a_rvalid_n;
         b_rvalid  <= b_rvalid_n;
         a_rdata   <= a_rdata_n;
         b_rdata   <= b_rdata_n;
         rd_err    <= rd_err_n;
         stale_cnt <= stale_cnt_n;
         tmo_cnt   <= tmo_cnt_n;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: arbitration order, write stall, read timeout with
// stale-response drop, zero-width writes and reset mid-read, against hand-computed values.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        a_req = 1'b0, a_we = 1'b0;
   logic [25:0] a_addr = '0;
   logic [31:0] a_wdata = '0;
   logic [1:0]  a_width = '0;
   logic        a_gnt, a_rvalid;
   logic [31:0] a_rdata;
   logic        b_req = 1'b0, b_we = 1'b0;
   logic [25:0] b_addr = '0;
   logic [31:0] b_wdata = '0;
   logic [1:0]  b_width = '0;
   logic        b_gnt, b_rvalid;
   logic [31:0] b_rdata;
   logic        rd_err;
   int          errors = 0;
   int          checks = 0;
   logic        mon_on = 1'b0;

   mux_mem_interface mem_if ();

   mem_arbiter #(.ADDR_W(26), .RD_TIMEOUT(16), .ERR_DATA(32'hFFFF_FFFF)) dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_width(a_width),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_width(b_width),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .rd_err(rd_err),
      .mux_mem(mem_if)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic port_b, input logic req, input logic we,
                                input logic [25:0] addr, input logic [31:0] wdata,
                                input logic [1:0] width);
      if (port_b) begin
         b_req = req; b_we = we; b_addr = addr; b_wdata = wdata; b_width = width;
      end else begin
         a_req = req; a_we = we; a_addr = addr; a_wdata = wdata; a_width = width;
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_flags"}, 64'({a_gnt, b_gnt, a_rvalid, b_rvalid, rd_err,
                  mem_if.mem_rd, mem_if.mem_wr, mem_if.mem_data_width}), 64'd0);
      checkOutput({tag, "_rdata"}, {a_rdata, b_rdata}, 64'd0);
      checkOutput({tag, "_cmd"}, {6'd0, mem_if.mem_addr, mem_if.mem_wr_data}, 64'd0);
   endtask

   // Neither both clients' rvalid nor both memory strobes may ever be high together.
   always @(negedge clk) begin
      if (mon_on) begin
         checkOutput("rvalid_excl", 64'(a_rvalid & b_rvalid), 64'd0);
         checkOutput("cmd_excl", 64'(mem_if.mem_rd & mem_if.mem_wr), 64'd0);
      end
   end

   initial begin
      mem_if.mem_rd_ready = 1'b1;
      mem_if.mem_wr_ready = 1'b1;
      mem_if.mem_rd_valid = 1'b0;
      mem_if.mem_rd_data  = '0;
      repeat (3) tick;
      checkResetState("reset");
      rst = 1'b0;
      mon_on = 1'b1;

      $display("[TB] simultaneous reads, A wins first tie");
      applyStimulus(1'b0, 1'b1, 1'b0, 26'h000_0200, 32'h0, 2'b11);
      applyStimulus(1'b1, 1'b1, 1'b0, 26'h000_0300, 32'h0, 2'b10);
      tick;
      checkOutput("t2_gnt", 64'({a_gnt, b_gnt}), 64'b10);
      checkOutput("t2_nocmd", 64'({mem_if.mem_rd, mem_if.mem_wr}), 64'd0);
      a_req = 1'b0;
      tick;
      checkOutput("t2_a_rd", 64'({mem_if.mem_rd, mem_if.mem_wr, b_gnt, mem_if.mem_addr}),
                  64'({3'b100, 26'h000_0200}));
      tick;
      checkOutput("t2_a_acc", 64'(mem_if.mem_rd), 64'd0);
      mem_if.mem_rd_valid = 1'b1; mem_if.mem_rd_data = 32'h1111_1111;
      tick;
      mem_if.mem_rd_valid = 1'b0;
      checkOutput("t2_a_rvalid", 64'({a_rvalid, b_rvalid}), 64'b10);
      checkOutput("t2_a_rdata", 64'(a_rdata), 64'h1111_1111);
      tick;
      checkOutput("t2_b_gnt", 64'({a_gnt, b_gnt, a_rvalid}), 64'b010);
      b_req = 1'b0;
      tick;
      checkOutput("t2_b_rd", 64'({mem_if.mem_rd, mem_if.mem_data_width, mem_if.mem_addr}),
                  64'({1'b1, 2'b10, 26'h000_0300}));
      tick;
      tick;
      mem_if.mem_rd_valid = 1'b1; mem_if.mem_rd_data = 32'h2222_2222;
      tick;
      mem_if.mem_rd_valid = 1'b0;
      checkOutput("t2_b_rvalid", 64'({a_rvalid, b_rvalid}), 64'b01);
      checkOutput("t2_rdata", {a_rdata, b_rdata}, 64'h1111_1111_2222_2222);
      tick;
      checkOutput("t2_b_pulse", 64'(b_rvalid), 64'd0);

      $display("[TB] single word write from A");
      applyStimulus(1'b0, 1'b1, 1'b1, 26'h000_0100, 32'hA5A5_1234, 2'b11);
      tick;
      checkOutput("t1_gnt", 64'({a_gnt, b_gnt, mem_if.mem_wr}), 64'b100);
      a_req = 1'b0;
      tick;
      checkOutput("t1_wr", {mem_if.mem_wr, a_gnt, b_gnt, mem_if.mem_data_width,
                  mem_if.mem_addr, mem_if.mem_wr_data},
                  {1'b1, 2'b00, 2'b11, 26'h000_0100, 32'hA5A5_1234});
      tick;
      checkOutput("t1_wr_done", 64'(mem_if.mem_wr), 64'd0);

      $display("[TB] write stalled by mem_wr_ready");
      mem_if.mem_wr_ready = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b1, 26'h3FF_FFFC, 32'hCAFE_BABE, 2'b10);
      tick;
      checkOutput("t3_gnt", 64'({a_gnt, b_gnt}), 64'b01);
      b_req = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0, 26'h000_0040, 32'h0, 2'b11);
      tick;
      for (int k = 0; k < 20; k++) begin
         checkOutput("t3_stall", {mem_if.mem_wr, a_gnt, b_gnt, mem_if.mem_data_width,
                     mem_if.mem_addr, mem_if.mem_wr_data},
                     {1'b1, 2'b00, 2'b10, 26'h3FF_FFFC, 32'hCAFE_BABE});
         if (k == 19) mem_if.mem_wr_ready = 1'b1;
         tick;
      end
      checkOutput("t3_accept", 64'({mem_if.mem_wr, a_gnt}), 64'b00);
      tick;
      checkOutput("t3_next_gnt", 64'({a_gnt, b_gnt}), 64'b10);
      a_req = 1'b0;
      tick;
      checkOutput("t3_next_rd", 64'({mem_if.mem_rd, mem_if.mem_addr}),
                  64'({1'b1, 26'h000_0040}));
      tick;
      mem_if.mem_rd_valid = 1'b1; mem_if.mem_rd_data = 32'h0000_5A5A;
      tick;
      mem_if.mem_rd_valid = 1'b0;
      checkOutput("t3_rdata", 64'({a_rvalid, a_rdata}), 64'({1'b1, 32'h0000_5A5A}));

      $display("[TB] read timeout on B then stale drop");
      applyStimulus(1'b1, 1'b1, 1'b0, 26'h000_0123, 32'h0, 2'b11);
      tick;
      checkOutput("t4_gnt", 64'({a_gnt, b_gnt}), 64'b01);
      b_req = 1'b0;
      tick;
      tick;
      checkOutput("t4_acc", 64'(mem_if.mem_rd), 64'd0);
      for (int k = 1; k < 16; k++) begin
         tick;
         checkOutput("t4_wait", 64'({b_rvalid, rd_err}), 64'd0);
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 26'h000_0456, 32'h0, 2'b11);
      tick;
      checkOutput("t4_timeout", 64'({b_rvalid, rd_err, b_rdata}),
                  64'({2'b11, 32'hFFFF_FFFF}));
      tick;
      checkOutput("t4_a_gnt", 64'({a_gnt, b_rvalid}), 64'b10);
      a_req = 1'b0;
      tick;
      tick;
      mem_if.mem_rd_valid = 1'b1; mem_if.mem_rd_data = 32'hDEAD_0000;
      tick;
      checkOutput("t4_stale", 64'({a_rvalid, b_rvalid}), 64'd0);
      mem_if.mem_rd_data = 32'h0000_00AB;
      tick;
      mem_if.mem_rd_valid = 1'b0;
      checkOutput("t4_a_rdata", 64'({a_rvalid, rd_err, a_rdata}),
                  64'({2'b11, 32'h0000_00AB}));

      $display("[TB] zero-width write");
      applyStimulus(1'b0, 1'b1, 1'b1, 26'h000_0010, 32'h5555_5555, 2'b00);
      tick;
      checkOutput("t5_gnt", 64'({a_gnt, mem_if.mem_wr}), 64'b10);
      a_req = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b1, 26'h000_0020, 32'h0000_0077, 2'b01);
      tick;
      checkOutput("t5_next_gnt", 64'({a_gnt, b_gnt, mem_if.mem_wr}), 64'b010);
      b_req = 1'b0;
      tick;
      checkOutput("t5_b_wr", {mem_if.mem_wr, 3'b000, mem_if.mem_data_width,
                  mem_if.mem_addr, mem_if.mem_wr_data},
                  {1'b1, 3'b000, 2'b01, 26'h000_0020, 32'h0000_0077});
      tick;

      $display("[TB] reset during WAIT_RD");
      applyStimulus(1'b0, 1'b1, 1'b0, 26'h000_0080, 32'h0, 2'b11);
      tick;
      a_req = 1'b0;
      tick;
      tick;
      tick;
      rst = 1'b1;
      tick;
      checkResetState("t6_reset");
      rst = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0, 26'h000_0084, 32'h0, 2'b10);
      tick;
      checkOutput("t6_gnt", 64'({a_gnt, b_gnt}), 64'b10);
      a_req = 1'b0;
      tick;
      tick;
      mem_if.mem_rd_valid = 1'b1; mem_if.mem_rd_data = 32'h1357_9BDF;
      tick;
      mem_if.mem_rd_valid = 1'b0;
      checkOutput("t6_rdata", 64'({a_rvalid, rd_err, a_rdata}),
                  64'({2'b10, 32'h1357_9BDF}));
      tick;

      mon_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
